// File: rtl/hazard_tracker.sv
// Purpose : carries register addresses and control tags D->E->M->W and derives the hazard-unit inputs.
// Latency : D tag visible in E after 1 cycle, M after 2, W after 3; Match_12D_E/PCWrPendingF are combinational on D.
// Backpressure: none held here; a stall arrives as FlushE, which bubbles E. Optional macro: HZT_R15_FILTER_EN.
module hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             StallD,
  input  logic             FlushE,
  input  logic             cnt_clr,
  output logic             Match_1E_M,
  output logic             Match_1E_W,
  output logic             Match_2E_M,
  output logic             Match_2E_W,
  output logic             Match_12D_E,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegE,
  output logic             PCSrcW,
  output logic             BranchTakenE,
  output logic             PCWrPendingF,
  output logic [3:0]       WA3W,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Address compare used by every Match output. With the R15 filter, PC reads
  // return PC+8 and never forward or interlock, so any compare touching R15 is 0.
  function automatic logic addr_eq(input logic [3:0] a, input logic [3:0] b);
`ifdef HZT_R15_FILTER_EN
    return (a == b) && (a != 4'd15) && (b != 4'd15);
`else
    return (a == b);
`endif
  endfunction

  // Execute stage state
  logic [3:0] ra1_e_q, ra1_e_d;
  logic [3:0] ra2_e_q, ra2_e_d;
  logic [3:0] wa3_e_q, wa3_e_d;
  logic       regwrite_e_q, regwrite_e_d;
  logic       memtoreg_e_q, memtoreg_e_d;
  logic       branch_e_q, branch_e_d;
  logic       pcsrc_e_q, pcsrc_e_d;

  // Memory stage state
  logic [3:0] wa3_m_q, wa3_m_d;
  logic       regwrite_m_q, regwrite_m_d;
  logic       pcsrc_m_q, pcsrc_m_d;

  // Writeback stage state
  logic [3:0] wa3_w_q, wa3_w_d;
  logic       regwrite_w_q, regwrite_w_d;
  logic       pcsrc_w_q, pcsrc_w_d;

  // Performance counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic branch_taken_e;

  assign branch_taken_e = branch_e_q & CondExE;

  // E next state: addresses always load; FlushE turns the control tags into a bubble.
  // StallD deliberately does not hold E because the hazard unit always pairs it with FlushE.
  always_comb begin
    ra1_e_d      = RA1D;
    ra2_e_d      = RA2D;
    wa3_e_d      = WA3D;
    regwrite_e_d = RegWriteD & ~FlushE;
    memtoreg_e_d = MemtoRegD & ~FlushE;
    branch_e_d   = BranchD   & ~FlushE;
    pcsrc_e_d    = PCSrcD    & ~FlushE;
  end

  // M next state: architectural writes only survive if the E condition passed.
  always_comb begin
    wa3_m_d      = wa3_e_q;
    regwrite_m_d = regwrite_e_q & CondExE;
    pcsrc_m_d    = pcsrc_e_q & CondExE;
  end

  // W next state: straight copy of M.
  always_comb begin
    wa3_w_d      = wa3_m_q;
    regwrite_w_d = regwrite_m_q;
    pcsrc_w_d    = pcsrc_m_q;
  end

  // Counter next state: clear wins over increment; both saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallD && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (branch_taken_e && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  // E register; reset overrides everything including FlushE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_e_q      <= '0;
      ra2_e_q      <= '0;
      wa3_e_q      <= '0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      branch_e_q   <= 1'b0;
      pcsrc_e_q    <= 1'b0;
    end else begin
      ra1_e_q      <= ra1_e_d;
      ra2_e_q      <= ra2_e_d;
      wa3_e_q      <= wa3_e_d;
      regwrite_e_q <= regwrite_e_d;
      memtoreg_e_q <= memtoreg_e_d;
      branch_e_q   <= branch_e_d;
      pcsrc_e_q    <= pcsrc_e_d;
    end
  end

  // M register; reset discards any in-flight write tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wa3_m_q      <= '0;
      regwrite_m_q <= 1'b0;
      pcsrc_m_q    <= 1'b0;
    end else begin
      wa3_m_q      <= wa3_m_d;
      regwrite_m_q <= regwrite_m_d;
      pcsrc_m_q    <= pcsrc_m_d;
    end
  end

  // W register; reset discards any in-flight write tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wa3_w_q      <= '0;
      regwrite_w_q <= 1'b0;
      pcsrc_w_q    <= 1'b0;
    end else begin
      wa3_w_q      <= wa3_w_d;
      regwrite_w_q <= regwrite_w_d;
      pcsrc_w_q    <= pcsrc_w_d;
    end
  end

  // Counter registers; reset wins over cnt_clr and increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Raw (or R15-filtered) address compares; RegWrite/MemtoReg qualification lives in the hazard unit.
  always_comb begin
    Match_1E_M  = addr_eq(ra1_e_q, wa3_m_q);
    Match_1E_W  = addr_eq(ra1_e_q, wa3_w_q);
    Match_2E_M  = addr_eq(ra2_e_q, wa3_m_q);
    Match_2E_W  = addr_eq(ra2_e_q, wa3_w_q);
    Match_12D_E = addr_eq(RA1D, wa3_e_q) | addr_eq(RA2D, wa3_e_q);
  end

  // Tag outputs for the hazard unit; PCWrPendingF spans D, E and M of an R15 writer.
  always_comb begin
    RegWriteM    = regwrite_m_q;
    RegWriteW    = regwrite_w_q;
    MemtoRegE    = memtoreg_e_q;
    PCSrcW       = pcsrc_w_q;
    BranchTakenE = branch_taken_e;
    PCWrPendingF = PCSrcD | pcsrc_e_q | pcsrc_m_q;
    WA3W         = wa3_w_q;
    stall_cnt    = stall_cnt_q;
    flush_cnt    = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Purpose : self-checking bench for hazard_tracker against an instruction-history reference model.
// Latency : inputs change on the falling edge, outputs are sampled shortly after, state advances on the rising edge.
// Backpressure: not applicable; the bench drives every cycle.
module tb_hazard_tracker;
  localparam int CNT_W = 16;
  localparam int unsigned CMAX = (32'd1 << CNT_W) - 32'd1;
`ifdef HZT_R15_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [3:0]       RA1D, RA2D, WA3D;
  logic             RegWriteD, MemtoRegD, BranchD, PCSrcD;
  logic             CondExE, StallD, FlushE, cnt_clr;
  logic             Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic             RegWriteM, RegWriteW, MemtoRegE, PCSrcW, BranchTakenE, PCWrPendingF;
  logic [3:0]       WA3W;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_tracker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .StallD(StallD), .FlushE(FlushE), .cnt_clr(cnt_clr),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF),
    .WA3W(WA3W), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // One issued instruction as it entered Execute (controls already bubbled by FlushE).
  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mr;
    logic       br;
    logic       pc;
  } rec_t;

  // hist[k]: instruction issued k+1 cycles ago; condh[k]: CondExE seen k+1 cycles ago.
  rec_t        hist [3];
  bit          condh [2];
  int unsigned scnt, fcnt;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit meq(input logic [3:0] a, input logic [3:0] b);
    return (a == b) && !(FILT && (a == 4'd15 || b == 4'd15));
  endfunction

  task automatic idle();
    reset = 1'b0; RA1D = '0; RA2D = '0; WA3D = '0;
    RegWriteD = 1'b0; MemtoRegD = 1'b0; BranchD = 1'b0; PCSrcD = 1'b0;
    CondExE = 1'b0; StallD = 1'b0; FlushE = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic check_all();
    rec_t e, m, w;
    bit   cm, cw;
    e = hist[0]; m = hist[1]; w = hist[2];
    cm = condh[0]; cw = condh[1];
    chk("RegWriteM",    32'(RegWriteM),    32'(m.rw & cm));
    chk("RegWriteW",    32'(RegWriteW),    32'(w.rw & cw));
    chk("MemtoRegE",    32'(MemtoRegE),    32'(e.mr));
    chk("PCSrcW",       32'(PCSrcW),       32'(w.pc & cw));
    chk("BranchTakenE", 32'(BranchTakenE), 32'(e.br & CondExE));
    chk("PCWrPendingF", 32'(PCWrPendingF), 32'(PCSrcD | e.pc | (m.pc & cm)));
    chk("WA3W",         32'(WA3W),         32'(w.wa3));
    chk("Match_1E_M",   32'(Match_1E_M),   32'(meq(e.ra1, m.wa3)));
    chk("Match_1E_W",   32'(Match_1E_W),   32'(meq(e.ra1, w.wa3)));
    chk("Match_2E_M",   32'(Match_2E_M),   32'(meq(e.ra2, m.wa3)));
    chk("Match_2E_W",   32'(Match_2E_W),   32'(meq(e.ra2, w.wa3)));
    chk("Match_12D_E",  32'(Match_12D_E),  32'(meq(RA1D, e.wa3) | meq(RA2D, e.wa3)));
    chk("stall_cnt",    32'(stall_cnt),    scnt);
    chk("flush_cnt",    32'(flush_cnt),    fcnt);
  endtask

  task automatic model_update();
    rec_t nr;
    bit   taken;
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      condh[0] = 1'b0; condh[1] = 1'b0;
      scnt = 0; fcnt = 0;
    end else begin
      taken = hist[0].br & CondExE;
      if (cnt_clr) begin
        scnt = 0; fcnt = 0;
      end else begin
        if (StallD && scnt < CMAX) scnt++;
        if (taken && fcnt < CMAX) fcnt++;
      end
      nr.ra1 = RA1D; nr.ra2 = RA2D; nr.wa3 = WA3D;
      nr.rw = RegWriteD & ~FlushE; nr.mr = MemtoRegD & ~FlushE;
      nr.br = BranchD & ~FlushE;   nr.pc = PCSrcD & ~FlushE;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = nr;
      condh[1] = condh[0]; condh[0] = CondExE;
    end
  endtask

  task automatic step(input bit full);
    #1;
    if (full) check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    @(negedge clk);
    idle(); reset = 1'b1;
    step(1'b0); step(1'b0);

    // Reset state, then a write tag reaching M two cycles after Decode
    idle(); RegWriteD = 1'b1; WA3D = 4'd3; CondExE = 1'b1; #1;
    chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("rst_PCSrcW", 32'(PCSrcW), 32'd0);
    chk("rst_Match_1E_M", 32'(Match_1E_M), 32'd1);
    step(1'b1);
    idle(); CondExE = 1'b1; step(1'b1);
    idle(); #1; chk("rst_RegWriteM_late", 32'(RegWriteM), 32'd1); step(1'b1);

    // Back-to-back forward: ADD R3 then SUB reading R3
    idle(); WA3D = 4'd3; RegWriteD = 1'b1; RA1D = 4'd7; RA2D = 4'd7; step(1'b1);
    idle(); RA1D = 4'd3; CondExE = 1'b1; step(1'b1);
    idle(); #1; chk("fwd_1E_M", 32'(Match_1E_M), 32'd1); step(1'b1);
    // One instruction in between: forward from W
    idle(); WA3D = 4'd4; RegWriteD = 1'b1; step(1'b1);
    idle(); CondExE = 1'b1; step(1'b1);
    idle(); RA1D = 4'd4; step(1'b1);
    idle(); #1;
    chk("fwd_1E_W", 32'(Match_1E_W), 32'd1);
    chk("fwd_1E_M_off", 32'(Match_1E_M), 32'd0);
    step(1'b1);

    // Load-use followed by stall+flush
    idle(); cnt_clr = 1'b1; step(1'b1);
    idle(); WA3D = 4'd5; MemtoRegD = 1'b1; RegWriteD = 1'b1; step(1'b1);
    idle(); RA1D = 4'd9; RA2D = 4'd5; #1;
    chk("lu_Match_12D_E", 32'(Match_12D_E), 32'd1);
    chk("lu_MemtoRegE", 32'(MemtoRegE), 32'd1);
    chk("lu_stall_cnt0", 32'(stall_cnt), 32'd0);
    StallD = 1'b1; FlushE = 1'b1; WA3D = 4'd6;
    RegWriteD = 1'b1; MemtoRegD = 1'b1; BranchD = 1'b1; PCSrcD = 1'b1;
    step(1'b1);
    idle(); CondExE = 1'b1; #1;
    chk("lu_bubble_MemtoRegE", 32'(MemtoRegE), 32'd0);
    chk("lu_bubble_BranchTakenE", 32'(BranchTakenE), 32'd0);
    chk("lu_bubble_PCWrPendingF", 32'(PCWrPendingF), 32'd0);
    chk("lu_stall_cnt1", 32'(stall_cnt), 32'd1);
    step(1'b1);

    // Branch taken, then branch not taken
    idle(); cnt_clr = 1'b1; step(1'b1);
    idle(); BranchD = 1'b1; step(1'b1);
    idle(); CondExE = 1'b1; #1;
    chk("br_taken", 32'(BranchTakenE), 32'd1);
    chk("br_flush_cnt0", 32'(flush_cnt), 32'd0);
    step(1'b1);
    idle(); #1;
    chk("br_taken_once", 32'(BranchTakenE), 32'd0);
    chk("br_flush_cnt1", 32'(flush_cnt), 32'd1);
    step(1'b1);
    idle(); BranchD = 1'b1; RegWriteD = 1'b1; step(1'b1);
    idle(); CondExE = 1'b0; #1; chk("br_not_taken", 32'(BranchTakenE), 32'd0); step(1'b1);
    idle(); #1;
    chk("br_nt_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("br_nt_flush_cnt", 32'(flush_cnt), 32'd1);
    step(1'b1);

    // PC write pending window
    idle(); PCSrcD = 1'b1; #1; chk("pc_pend_c0", 32'(PCWrPendingF), 32'd1); step(1'b1);
    idle(); CondExE = 1'b1; #1; chk("pc_pend_c1", 32'(PCWrPendingF), 32'd1); step(1'b1);
    idle(); #1;
    chk("pc_pend_c2", 32'(PCWrPendingF), 32'd1);
    chk("pc_srcw_c2", 32'(PCSrcW), 32'd0);
    step(1'b1);
    idle(); #1;
    chk("pc_pend_c3", 32'(PCWrPendingF), 32'd0);
    chk("pc_srcw_c3", 32'(PCSrcW), 32'd1);
    step(1'b1);

    // R15 compare: filtered build reports no match
    idle(); WA3D = 4'd15; step(1'b1);
    idle(); RA1D = 4'd15; step(1'b1);
    idle(); #1; chk("r15_Match_1E_M", 32'(Match_1E_M), FILT ? 32'd0 : 32'd1); step(1'b1);

    // Reset mid-operation discards in-flight tags and counters
    idle(); RegWriteD = 1'b1; PCSrcD = 1'b1; StallD = 1'b0; step(1'b1);
    idle(); CondExE = 1'b1; reset = 1'b1; FlushE = 1'b1; cnt_clr = 1'b1; step(1'b1);
    idle(); #1;
    chk("mid_rst_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("mid_rst_PCWrPendingF", 32'(PCWrPendingF), 32'd0);
    step(1'b1);

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset     = ($urandom_range(0, 99) == 0);
      RA1D      = rnd_addr();
      RA2D      = rnd_addr();
      WA3D      = rnd_addr();
      RegWriteD = 1'($urandom_range(0, 1));
      MemtoRegD = 1'($urandom_range(0, 1));
      BranchD   = ($urandom_range(0, 3) == 0);
      PCSrcD    = ($urandom_range(0, 4) == 0);
      CondExE   = 1'($urandom_range(0, 1));
      StallD    = ($urandom_range(0, 7) == 0);
      FlushE    = StallD | ($urandom_range(0, 5) == 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      step(1'b1);
    end

    // Saturation of stall_cnt, then clear beats increment
    idle(); cnt_clr = 1'b1; step(1'b1);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      idle(); StallD = 1'b1; FlushE = 1'b1;
      step(1'b0);
    end
    idle(); StallD = 1'b1; FlushE = 1'b1; #1;
    chk("sat_stall_cnt", 32'(stall_cnt), CMAX);
    step(1'b1);
    idle(); StallD = 1'b1; FlushE = 1'b1; cnt_clr = 1'b1; step(1'b1);
    idle(); StallD = 1'b1; FlushE = 1'b1; #1;
    chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Pipeline-side companion of the hazard unit in the five-stage ARM core. It carries register addresses and control tags from Decode through Execute, Memory and Writeback. It produces the `Match_*`, `RegWrite*`, `MemtoRegE`, `PCWrPendingF`, `PCSrcW` and `BranchTakenE` signals that the hazard unit consumes, and it applies the hazard unit's `FlushE` back onto its own Execute register. It also keeps saturating counters of stall and branch-flush cycles for performance bring-up.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `RA1D`, `RA2D` input 4: Decode source register addresses.
- `WA3D` input 4: Decode destination register address.
- `RegWriteD`, `MemtoRegD`, `BranchD` input 1: Decode control bits.
- `PCSrcD` input 1: Decode instruction writes R15 (non-branch).
- `CondExE` input 1: condition check passed for the Execute instruction.
- `StallD`, `FlushE` input 1: from the hazard unit.
- `cnt_clr` input 1: clears both counters.
- `Match_1E_M`, `Match_1E_W`, `Match_2E_M`, `Match_2E_W` output 1: Execute source address equals Memory/Writeback destination.
- `Match_12D_E` output 1: either Decode source equals the Execute destination.
- `RegWriteM`, `RegWriteW`, `MemtoRegE`, `PCSrcW`, `BranchTakenE`, `PCWrPendingF` output 1: tags for the hazard unit.
- `WA3W` output 4: Writeback destination, for the register file.
- `stall_cnt`, `flush_cnt` output `CNT_W`: performance counters.

## Operation
- **E register.** Each cycle it loads `RA1D`, `RA2D`, `WA3D`, `RegWriteD`, `MemtoRegD`, `BranchD` and `PCSrcD`.
  - If `FlushE` is asserted, the control bits (RegWrite, MemtoReg, Branch, PCSrc) load 0. Addresses still load.
  - `StallD` does not hold this register. A stall is always accompanied by `FlushE` from the hazard unit.
- **M register.** Loads from E:
  - `RegWriteM` = `RegWriteE & CondExE`
  - `PCSrcM` = `PCSrcE & CondExE`
  - `MemtoRegM` = `MemtoRegE`
  - `WA3M` = `WA3E`
- **W register.** Loads from M unconditionally.
- **Combinational outputs:**
  - `Match_1E_M` = (`RA1E` == `WA3M`); `Match_2E_M` and `Match_*_W` follow the same pattern.
  - `Match_12D_E` = (`RA1D` == `WA3E`) | (`RA2D` == `WA3E`).
  - `BranchTakenE` = `BranchE & CondExE`.
  - `PCWrPendingF` = `PCSrcD | PCSrcE | PCSrcM`.
- Matches are raw address compares. Qualification by `RegWrite*` / `MemtoRegE` is done in the hazard unit.
- **`stall_cnt`** increments every cycle `StallD` = 1.
- **`flush_cnt`** increments every cycle `BranchTakenE` = 1.
- **Counter rules:**
  - Both counters saturate at all-ones and do not wrap.
  - `cnt_clr` has priority over increment; the result is 0 the next cycle.

## Timing
- **Reset.** All E/M/W control bits are 0, all address registers are 0, and both counters are 0.
  - Consequently `RegWriteM/W`, `MemtoRegE`, `PCSrcW` and `BranchTakenE` are 0 the cycle after reset.
  - `Match_*_M/W` are 1, because all stage addresses are 0 and compare equal. This is harmless because the RegWrite tags are 0.
- **Reset mid-operation.** Discards all in-flight tags the next cycle. `reset` has priority over `FlushE` and `cnt_clr`.
- **Latency.**
  - A Decode tag appears in E 1 cycle later, M 2 cycles later, W 3 cycles later.
  - `PCWrPendingF` is asserted from the Decode cycle through the M cycle of an R15 writer, then `PCSrcW` is high for one cycle.
- **Simultaneous events.**
  - `FlushE` together with a `CondExE` failure: E controls are cleared and M receives the gated values of the current E.
  - `StallD` with `FlushE` on the same edge: E becomes a bubble and `stall_cnt` increments.
- **Combinational paths.** `Match_12D_E` and `PCWrPendingF` depend combinationally on D inputs. All other outputs depend only on registers and `CondExE`.

## Configuration
- **`HZT_R15_FILTER_EN` defined:** every `Match_*` output is forced to 0 whenever either compared address is 15. R15 reads return PC+8 and are never forwarded or interlocked.
- **Not defined:** raw compares include R15.

## Test plan
- **Reset:** after reset, drive `RegWriteD`=1, `WA3D`=3. Required: `RegWriteM` is 0 in the first cycle after reset, then 1 two cycles after the Decode cycle when `CondExE`=1.
- **Forward match:** issue `ADD R3,...` then `SUB ..,R3,..` on consecutive cycles. Required: `Match_1E_M`=1 in the SUB's Execute cycle, and `Match_1E_W`=1 if one instruction separates them.
- **Load-use:**
  - Step 1: `LDR R5` with `MemtoRegD`=1 is in E while `RA2D`=5 is in D. Required: `Match_12D_E`=1 and `MemtoRegE`=1.
  - Step 2: drive `StallD`=`FlushE`=1. Required: the next E control bits are all 0 and `stall_cnt` goes 0→1.
- **Branch:** `BranchD`=1, then `CondExE`=1. Required: `BranchTakenE`=1 for one cycle and `flush_cnt`=1. With `CondExE`=0, `BranchTakenE`=0 and `RegWriteM`=0.
- **PC write:** `PCSrcD`=1 in cycle 0. Required: `PCWrPendingF`=1 in cycles 0–2 and `PCSrcW`=1 in cycle 3. Under `HZT_R15_FILTER_EN`, `RA1E`=15 gives `Match_1E_M`=0.
- **Counter saturation:** hold `StallD`=1 for 2^`CNT_W`+5 cycles. Required: `stall_cnt` stops at 0xFFFF. Then `cnt_clr`=1 gives 0 the next cycle, even with `StallD`=1.
